// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state encoding,
// stage-control patterns and the NOP opcode forced into bubbled stages.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_MISS_WAIT = 2'd2
  } pipeState_e;

  localparam int REG_ADDR_W = 32'd3;

  localparam logic [3:0] COP_NOP = 4'd0;

  // Stage control bundle order: {pc, decode, alu, tlblookup, bubble_alu, flush_decode}
  localparam logic [5:0] CTRL_RUN   = 6'b111100;
  localparam logic [5:0] CTRL_HAZ   = 6'b001110;
  localparam logic [5:0] CTRL_FLUSH = 6'b111111;
  localparam logic [5:0] CTRL_HALT  = 6'b000000;
  localparam logic [5:0] CTRL_RESET = 6'b000010;

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register in-flight write counters with source-pending lookups, destination
// full detection and a sticky error flag for count underflow/overflow.
module pipe_scoreboard #(
  parameter int NUM_REGS   = 32'd8,
  parameter int REG_ADDR_W = 32'd3,
  parameter int CNT_W      = 32'd2,
  parameter int WB_BYPASS  = 32'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  incEn,
  input  logic [REG_ADDR_W-1:0] incAddr,
  input  logic                  decEn,
  input  logic [REG_ADDR_W-1:0] decAddr,
  input  logic [REG_ADDR_W-1:0] srcAAddr,
  input  logic [REG_ADDR_W-1:0] srcBAddr,
  input  logic [REG_ADDR_W-1:0] destAddr,
  output logic                  pendA,
  output logic                  pendB,
  output logic                  destFull,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0]    cnt_r [NUM_REGS];
  logic                overflow_r;
  logic [NUM_REGS-1:0] incVec_s;
  logic [NUM_REGS-1:0] decVec_s;

  // A register whose last outstanding write retires this cycle can be bypassed.
  function automatic logic pendingOf(input logic [CNT_W-1:0] cnt, input logic retireHit);
    pendingOf = (cnt != CNT_ZERO) && !((WB_BYPASS != 0) && retireHit && (cnt == CNT_ONE));
  endfunction

  // Decode inc/dec requests into one-hot per-register strobes.
  always_comb begin
    incVec_s = {NUM_REGS{1'b0}};
    decVec_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      incVec_s[i] = incEn & (incAddr == REG_ADDR_W'(i));
      decVec_s[i] = decEn & (decAddr == REG_ADDR_W'(i));
    end
  end

  // Lookups seen by decode.
  always_comb begin
    pendA    = pendingOf(cnt_r[srcAAddr], decEn && (decAddr == srcAAddr));
    pendB    = pendingOf(cnt_r[srcBAddr], decEn && (decAddr == srcBAddr));
    destFull = (cnt_r[destAddr] == CNT_MAX);
  end

  // Counter update; simultaneous inc and dec on one register cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      overflow_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (incVec_s[i] && !decVec_s[i]) begin
          if (cnt_r[i] == CNT_MAX) begin
            overflow_r <= 1'b1;
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_ONE;
          end
        end else if (decVec_s[i] && !incVec_s[i]) begin
          if (cnt_r[i] == CNT_ZERO) begin
            overflow_r <= 1'b1;
          end else begin
            cnt_r[i] <= cnt_r[i] - CNT_ONE;
          end
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign overflow = overflow_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: RAW-hazard stalls, branch squash and TLB-miss freeze for the
// fetch/decode/alu/tlblookup/writeback core, plus a saturating stall counter.
module pipe_ctrl #(
  parameter int NUM_REGS       = 32'd8,
  parameter int REG_ADDR_W     = 32'd3,
  parameter int CNT_W          = 32'd2,
  parameter int BRANCH_PENALTY = 32'd1,
  parameter int MISS_TIMEOUT   = 32'd64,
  parameter int WB_BYPASS      = 32'd1,
  parameter int PERF_W         = 32'd16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_valid_dec,
  input  logic [REG_ADDR_W-1:0] srcA_addr,
  input  logic                  srcA_used,
  input  logic [REG_ADDR_W-1:0] srcB_addr,
  input  logic                  srcB_used,
  input  logic [REG_ADDR_W-1:0] destReg_addr_dec,
  input  logic                  we_dec,
  input  logic                  branch_taken,
  input  logic                  tlb_miss,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] destReg_addr_wb,
  input  logic                  we_wb,
  output logic                  enable_pc,
  output logic                  enable_decode,
  output logic                  enable_alu,
  output logic                  enable_tlblookup,
  output logic                  bubble_alu,
  output logic                  flush_decode,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic                  sb_overflow,
  output logic                  miss_timeout,
  output logic [1:0]            state_o
);

  import pipe_ctrl_pkg::*;

  localparam int FCNT_W = $clog2(BRANCH_PENALTY + 1);
  localparam int TCNT_W = $clog2(MISS_TIMEOUT) + 1;
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(BRANCH_PENALTY);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(32'd1);
  localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(32'd1);
  localparam logic [TCNT_W-1:0] TCNT_ZERO = {TCNT_W{1'b0}};
  localparam logic [TCNT_W-1:0] TCNT_MAX  = {TCNT_W{1'b1}};
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MISS_TIMEOUT - 32'd1);
  localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(32'd1);
  localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

  pipeState_e        state_r;
  logic [FCNT_W-1:0] fCnt_r;
  logic [TCNT_W-1:0] tCnt_r;
  logic              missTimeout_r;
  logic              wbFresh_r;
  logic [PERF_W-1:0] stallCnt_r;

  logic       pendA_s;
  logic       pendB_s;
  logic       destFull_s;
  logic       hazard_s;
  logic       issue_s;
  logic       retire_s;
  logic [5:0] ctrl_s;

  assign hazard_s = inst_valid_dec & ((srcA_used & pendA_s) | (srcB_used & pendB_s)
                                      | (we_dec & destFull_s));
  assign issue_s  = (state_r == ST_RUN) & inst_valid_dec & ~hazard_s & ~tlb_miss & ~reset;
  // Only a writeback that advanced last cycle is new; a frozen one must not retire twice.
  assign retire_s = we_wb & wbFresh_r & ~reset;

  pipe_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W),
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .incEn   (issue_s & we_dec),
    .incAddr (destReg_addr_dec),
    .decEn   (retire_s),
    .decAddr (destReg_addr_wb),
    .srcAAddr(srcA_addr),
    .srcBAddr(srcB_addr),
    .destAddr(destReg_addr_dec),
    .pendA   (pendA_s),
    .pendB   (pendB_s),
    .destFull(destFull_s),
    .overflow(sb_overflow)
  );

  // Stage controls; a TLB miss outranks branch squash, which outranks a data hazard.
  always_comb begin
    ctrl_s = CTRL_HALT;
    if (reset) begin
      ctrl_s = CTRL_RESET;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (tlb_miss) begin
            ctrl_s = CTRL_HALT;
          end else if (hazard_s) begin
            ctrl_s = CTRL_HAZ;
          end else begin
            ctrl_s = CTRL_RUN;
          end
        end
        ST_FLUSH: begin
          if (tlb_miss) begin
            ctrl_s = CTRL_HALT;
          end else begin
            ctrl_s = CTRL_FLUSH;
          end
        end
        ST_MISS_WAIT: ctrl_s = CTRL_HALT;
        default:      ctrl_s = CTRL_RESET;
      endcase
    end
  end

  assign {enable_pc, enable_decode, enable_alu, enable_tlblookup, bubble_alu, flush_decode} = ctrl_s;

  // Controller FSM with flush and miss-wait counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RUN;
      fCnt_r        <= FCNT_ZERO;
      tCnt_r        <= TCNT_ZERO;
      missTimeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (tlb_miss) begin
            state_r <= ST_MISS_WAIT;
            tCnt_r  <= TCNT_ZERO;
          end else if (issue_s && branch_taken) begin
            state_r <= ST_FLUSH;
            fCnt_r  <= FCNT_INIT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (tlb_miss) begin
            state_r <= ST_MISS_WAIT;
            tCnt_r  <= TCNT_ZERO;
          end else begin
            fCnt_r  <= fCnt_r - FCNT_ONE;
            state_r <= (fCnt_r == FCNT_ONE) ? ST_RUN : ST_FLUSH;
          end
        end
        ST_MISS_WAIT: begin
          if (mem_ready) begin
            tCnt_r  <= TCNT_ZERO;
            state_r <= (fCnt_r != FCNT_ZERO) ? ST_FLUSH : ST_RUN;
          end else begin
            if (tCnt_r != TCNT_MAX) begin
              tCnt_r <= tCnt_r + TCNT_ONE;
            end
            if (tCnt_r == TCNT_LAST) begin
              missTimeout_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_RUN;
          fCnt_r  <= FCNT_ZERO;
          tCnt_r  <= TCNT_ZERO;
        end
      endcase
    end
  end

  // Writeback freshness tracker and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbFresh_r  <= 1'b0;
      stallCnt_r <= {PERF_W{1'b0}};
    end else begin
      wbFresh_r <= enable_tlblookup;
      if (!enable_pc && (stallCnt_r != PERF_MAX)) begin
        stallCnt_r <= stallCnt_r + PERF_ONE;
      end
    end
  end

  assign stall_cycles = stallCnt_r;
  assign miss_timeout = missTimeout_r;
  assign state_o      = state_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard stall/bypass, branch squash, TLB-miss freeze,
// miss timeout, scoreboard error and mid-miss reset, with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        inst_valid_dec;
  logic [2:0]  srcA_addr;
  logic        srcA_used;
  logic [2:0]  srcB_addr;
  logic        srcB_used;
  logic [2:0]  destReg_addr_dec;
  logic        we_dec;
  logic        branch_taken;
  logic        tlb_miss;
  logic        mem_ready;
  logic [2:0]  destReg_addr_wb;
  logic        we_wb;
  logic        enable_pc;
  logic        enable_decode;
  logic        enable_alu;
  logic        enable_tlblookup;
  logic        bubble_alu;
  logic        flush_decode;
  logic [15:0] stall_cycles;
  logic        sb_overflow;
  logic        miss_timeout;
  logic [1:0]  state_o;
  logic [5:0]  ctrl;

  int numChecks = 0;
  int numPassed = 0;

  // {pc, decode, alu, tlblookup, bubble_alu, flush_decode}
  localparam logic [5:0] C_RUN   = 6'b111100;
  localparam logic [5:0] C_HAZ   = 6'b001110;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_HALT  = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b000010;

  assign ctrl = {enable_pc, enable_decode, enable_alu, enable_tlblookup, bubble_alu, flush_decode};

  pipe_ctrl #(
    .NUM_REGS      (8),
    .REG_ADDR_W    (3),
    .CNT_W         (2),
    .BRANCH_PENALTY(2),
    .MISS_TIMEOUT  (64),
    .WB_BYPASS     (1),
    .PERF_W        (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_valid_dec  (inst_valid_dec),
    .srcA_addr       (srcA_addr),
    .srcA_used       (srcA_used),
    .srcB_addr       (srcB_addr),
    .srcB_used       (srcB_used),
    .destReg_addr_dec(destReg_addr_dec),
    .we_dec          (we_dec),
    .branch_taken    (branch_taken),
    .tlb_miss        (tlb_miss),
    .mem_ready       (mem_ready),
    .destReg_addr_wb (destReg_addr_wb),
    .we_wb           (we_wb),
    .enable_pc       (enable_pc),
    .enable_decode   (enable_decode),
    .enable_alu      (enable_alu),
    .enable_tlblookup(enable_tlblookup),
    .bubble_alu      (bubble_alu),
    .flush_decode    (flush_decode),
    .stall_cycles    (stall_cycles),
    .sb_overflow     (sb_overflow),
    .miss_timeout    (miss_timeout),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got === exp) begin
      numPassed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; new inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic au, input logic [2:0] b,
                       input logic bu, input logic [2:0] d, input logic w, input logic br);
    inst_valid_dec   = v;
    srcA_addr        = a;
    srcA_used        = au;
    srcB_addr        = b;
    srcB_used        = bu;
    destReg_addr_dec = d;
    we_dec           = w;
    branch_taken     = br;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tlb_miss        = 1'b0;
    mem_ready       = 1'b0;
    destReg_addr_wb = 3'd0;
    we_wb           = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    cyc(); #1 checkVal("rst_ctrl", 32'(ctrl), 32'(C_RST));
    cyc(); reset = 1'b0; #1;
    checkVal("post_rst_state", 32'(state_o), 32'd0);
    checkVal("post_rst_stall", 32'(stall_cycles), 32'd0);
    checkVal("post_rst_flags", {30'd0, sb_overflow, miss_timeout}, 32'd0);
    checkVal("post_rst_ctrl", 32'(ctrl), 32'(C_RUN));

    // RAW on r3: stall until r3 retires, then issue via writeback bypass
    cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0); #1 checkVal("raw_issue", 32'(ctrl), 32'(C_RUN));
    cyc(); drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1 checkVal("raw_stall1", 32'(ctrl), 32'(C_HAZ));
    cyc(); #1 checkVal("raw_stall2", 32'(ctrl), 32'(C_HAZ));
    cyc(); we_wb = 1'b1; destReg_addr_wb = 3'd3; #1 checkVal("raw_bypass", 32'(ctrl), 32'(C_RUN));
    cyc(); idle(); #1 checkVal("raw_stall_cnt", 32'(stall_cycles), 32'd2);

    // Fill r1 to the counter maximum; a fourth writer must wait
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0); #1 checkVal("full_fill", 32'(ctrl), 32'(C_RUN));
    end
    cyc(); #1 checkVal("full_haz", 32'(ctrl), 32'(C_HAZ));
    cyc(); we_wb = 1'b1; destReg_addr_wb = 3'd1; #1 checkVal("full_haz_retire", 32'(ctrl), 32'(C_HAZ));
    cyc(); we_wb = 1'b0; #1 checkVal("full_reissue", 32'(ctrl), 32'(C_RUN));
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); we_wb = 1'b1; destReg_addr_wb = 3'd1;
    end
    cyc(); we_wb = 1'b0; drive(1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0); #1;
    checkVal("srcB_free", 32'(ctrl), 32'(C_RUN));
    checkVal("full_stall_cnt", 32'(stall_cycles), 32'd4);
    checkVal("full_no_ovf", 32'(sb_overflow), 32'd0);

    // Taken branch: two squash cycles, the squashed writer of r6 is not recorded
    cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); #1 checkVal("br_issue", 32'(ctrl), 32'(C_RUN));
    cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0); #1;
    checkVal("br_flush1", 32'(ctrl), 32'(C_FLUSH));
    checkVal("br_state", 32'(state_o), 32'd1);
    cyc(); #1 checkVal("br_flush2", 32'(ctrl), 32'(C_FLUSH));
    cyc(); drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
    checkVal("br_done", 32'(ctrl), 32'(C_RUN));
    checkVal("br_run", 32'(state_o), 32'd0);

    // mem_ready outside a miss is ignored
    cyc(); idle(); mem_ready = 1'b1; #1 checkVal("mr_ignored", 32'(ctrl), 32'(C_RUN));
    cyc(); mem_ready = 1'b0; #1 checkVal("mr_state", 32'(state_o), 32'd0);

    // Five-cycle TLB miss with a writeback held frozen across it
    cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0); #1 checkVal("miss_pre", 32'(ctrl), 32'(C_RUN));
    cyc(); drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    we_wb = 1'b1; destReg_addr_wb = 3'd2; tlb_miss = 1'b1; #1 checkVal("miss_c1", 32'(ctrl), 32'(C_HALT));
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      checkVal("miss_hold", 32'(ctrl), 32'(C_HALT));
      checkVal("miss_state", 32'(state_o), 32'd2);
    end
    cyc(); tlb_miss = 1'b0; mem_ready = 1'b1; #1 checkVal("miss_ready", 32'(ctrl), 32'(C_HALT));
    cyc(); mem_ready = 1'b0; #1;
    checkVal("miss_resume", 32'(ctrl), 32'(C_RUN));
    checkVal("miss_run", 32'(state_o), 32'd0);
    cyc(); we_wb = 1'b0; drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
    checkVal("miss_wb_once", 32'(ctrl), 32'(C_RUN));
    checkVal("miss_no_ovf", 32'(sb_overflow), 32'd0);
    checkVal("miss_stall_cnt", 32'(stall_cycles), 32'd10);

    // Miss during the second flush slot returns to a single flush cycle
    cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); #1 checkVal("fm_branch", 32'(ctrl), 32'(C_RUN));
    cyc(); idle(); #1 checkVal("fm_flush", 32'(ctrl), 32'(C_FLUSH));
    cyc(); tlb_miss = 1'b1; #1 checkVal("fm_miss", 32'(ctrl), 32'(C_HALT));
    cyc(); tlb_miss = 1'b0; mem_ready = 1'b1; #1 checkVal("fm_wait", 32'(state_o), 32'd2);
    cyc(); mem_ready = 1'b0; #1;
    checkVal("fm_reflush", 32'(ctrl), 32'(C_FLUSH));
    checkVal("fm_reflush_state", 32'(state_o), 32'd1);
    cyc(); #1;
    checkVal("fm_run", 32'(ctrl), 32'(C_RUN));
    checkVal("fm_stall_cnt", 32'(stall_cycles), 32'd12);

    // Miss timeout after 64 waiting cycles; FSM keeps waiting
    cyc(); tlb_miss = 1'b1; #1 checkVal("to_enter", 32'(ctrl), 32'(C_HALT));
    cyc(); tlb_miss = 1'b0; #1 checkVal("to_state", 32'(state_o), 32'd2);
    repeat (63) cyc();
    #1 checkVal("to_before", 32'(miss_timeout), 32'd0);
    cyc(); #1;
    checkVal("to_set", 32'(miss_timeout), 32'd1);
    checkVal("to_still_wait", 32'(state_o), 32'd2);
    checkVal("to_stall_cnt", 32'(stall_cycles), 32'd77);
    cyc(); mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0; #1;
    checkVal("to_exit", 32'(state_o), 32'd0);
    checkVal("to_sticky", 32'(miss_timeout), 32'd1);

    // Retiring a register with nothing in flight raises the sticky error
    cyc(); we_wb = 1'b1; destReg_addr_wb = 3'd7;
    cyc(); we_wb = 1'b0; #1 checkVal("ovf_set", 32'(sb_overflow), 32'd1);

    // Reset while waiting on a miss with two writes to r5 pending
    cyc(); drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    cyc(); #1 checkVal("r5_issue2", 32'(ctrl), 32'(C_RUN));
    cyc(); idle(); tlb_miss = 1'b1;
    cyc(); tlb_miss = 1'b0; #1 checkVal("r5_wait", 32'(state_o), 32'd2);
    cyc(); reset = 1'b1; #1 checkVal("rst_mid_ctrl", 32'(ctrl), 32'(C_RST));
    cyc(); reset = 1'b0; drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
    checkVal("rst_mid_state", 32'(state_o), 32'd0);
    checkVal("rst_mid_stall", 32'(stall_cycles), 32'd0);
    checkVal("rst_mid_flags", {30'd0, sb_overflow, miss_timeout}, 32'd0);
    checkVal("rst_mid_sb_clear", 32'(ctrl), 32'(C_RUN));

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
